// File: rtl/pwm_duty_decoder.sv
// ============================================================================
// Module      : pwm_duty_decoder
// Description : Measures an asynchronous PWM waveform and recovers its duty
//               cycle as a 0..99 step value. Periods outside the accepted
//               window raise period_err; a missing rising edge marks the
//               input stale.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int STEP_CYCLES    = 20000,
  parameter int MIN_PERIOD     = 1800000,
  parameter int MAX_PERIOD     = 2200000,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [6:0] duty,
  output logic       duty_valid,
  output logic       period_err,
  output logic       stale
);

  // A single-flop synchronizer is never acceptable, so smaller values are
  // raised to two.
  localparam int c_SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int c_PER_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [c_PER_W-1:0]  c_TIMEOUT   = c_PER_W'(TIMEOUT_CYCLES);
  localparam logic [c_PER_W-1:0]  c_MIN_PER   = c_PER_W'(MIN_PERIOD);
  localparam logic [c_PER_W-1:0]  c_MAX_PER   = c_PER_W'(MAX_PERIOD);
  localparam logic [c_PER_W-1:0]  c_PER_ONE   = c_PER_W'(1);
  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CYCLES - 1);
  localparam logic [6:0]          c_DUTY_MAX  = 7'd99;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_HIGH = 2'd1;
  localparam logic [1:0] c_LOW  = 2'd2;

  logic [c_SYNC_N-1:0] r_sync;
  logic                r_prev;
  logic                r_rise;
  logic                r_fall;
  logic                w_rise_raw;
  logic                w_fall_raw;

  logic [1:0]          r_state;
  logic [c_PER_W-1:0]  r_per_cnt;
  logic [c_STEP_W-1:0] r_step_cnt;
  logic [6:0]          r_hi_steps;

  logic [c_PER_W-1:0]  w_per_next;
  logic                w_timeout;
  logic                w_in_range;

  assign w_rise_raw = r_sync[c_SYNC_N-1] & ~r_prev;
  assign w_fall_raw = ~r_sync[c_SYNC_N-1] & r_prev;

  // Period counter saturates so it can never wrap back into the valid window.
  assign w_per_next = (r_per_cnt == c_TIMEOUT) ? r_per_cnt : r_per_cnt + c_PER_ONE;
  assign w_timeout  = (r_per_cnt == c_TIMEOUT);
  assign w_in_range = (r_per_cnt >= c_MIN_PER) && (r_per_cnt <= c_MAX_PER);

  // Synchronize pwm_in and register the edge strobes the FSM consumes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[c_SYNC_N-2:0], pwm_in};
      r_prev <= r_sync[c_SYNC_N-1];
      r_rise <= w_rise_raw;
      r_fall <= w_fall_raw;
    end
  end

  // Measurement FSM: counts the period and high-time steps, publishes on the
  // rising edge that closes each period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= c_IDLE;
      r_per_cnt  <= '0;
      r_step_cnt <= '0;
      r_hi_steps <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      stale      <= 1'b1;
    end else begin
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      r_per_cnt  <= w_per_next;

      case (r_state)
        c_IDLE: begin
          if (r_rise) begin
            r_per_cnt  <= c_PER_ONE;
            r_step_cnt <= '0;
            r_hi_steps <= '0;
            r_state    <= c_HIGH;
          end
        end

        c_HIGH: begin
          if (w_timeout) begin
            // Constant-high input: keep the last duty, flag stale.
            stale   <= 1'b1;
            r_state <= c_IDLE;
          end else begin
            // The falling-edge cycle still counts as a high cycle.
            if (r_step_cnt == c_STEP_LAST) begin
              r_step_cnt <= '0;
              if (r_hi_steps != c_DUTY_MAX) begin
                r_hi_steps <= r_hi_steps + 7'd1;
              end
            end else begin
              r_step_cnt <= r_step_cnt + 1'b1;
            end
            if (r_fall) begin
              r_state <= c_LOW;
            end
          end
        end

        c_LOW: begin
          // A rise coinciding with the timeout is deliberately dropped.
          if (w_timeout) begin
            stale   <= 1'b1;
            r_state <= c_IDLE;
          end else if (r_rise) begin
            if (w_in_range) begin
              duty       <= r_hi_steps;
              duty_valid <= 1'b1;
              stale      <= 1'b0;
            end else begin
              period_err <= 1'b1;
            end
            // The closing edge also opens the next period.
            r_per_cnt  <= c_PER_ONE;
            r_step_cnt <= '0;
            r_hi_steps <= '0;
            r_state    <= c_HIGH;
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
// ============================================================================
// Module      : tb_pwm_duty_decoder
// Description : Directed, table-driven bench for pwm_duty_decoder using a
//               scaled-down timing set (10-cycle steps, 1000-cycle period).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_decoder;

  localparam int SYNC_STAGES    = 2;
  localparam int STEP_CYCLES    = 10;
  localparam int MIN_PERIOD     = 900;
  localparam int MAX_PERIOD     = 1100;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int N_ROWS         = 16;

  logic       clock;
  logic       reset;
  logic       pwm_in;
  logic [6:0] duty;
  logic       duty_valid;
  logic       period_err;
  logic       stale;

  // One PWM period starting with a rise, and what that rise must produce.
  typedef struct {
    int         high;
    int         period;
    logic       v;
    logic       e;
    logic [6:0] d;
    logic       s;
  } row_t;

  row_t tbl [N_ROWS];

  int n_checks;
  int n_errors;
  int mon_valid;
  int mon_err;
  int exp_valid;
  int exp_err;

  pwm_duty_decoder #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STEP_CYCLES   (STEP_CYCLES),
    .MIN_PERIOD    (MIN_PERIOD),
    .MAX_PERIOD    (MAX_PERIOD),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .duty_valid(duty_valid),
    .period_err(period_err),
    .stale     (stale)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every pulse cycle so spurious or stretched pulses show up.
  always @(negedge clock) begin
    if (duty_valid) mon_valid <= mon_valid + 1;
    if (period_err) mon_err   <= mon_err + 1;
  end

  function automatic row_t mk(input int h, input int p, input logic v,
                              input logic e, input int d, input logic s);
    row_t r;
    r.high   = h;
    r.period = p;
    r.v      = v;
    r.e      = e;
    r.d      = 7'(d);
    r.s      = s;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks = n_checks + 1;
    if (act !== expv) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Advance n clock edges, ending 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({duty_valid, period_err, stale, duty});
  endfunction

  // Rise, verify exact publish latency and result, then finish the period.
  task automatic apply_row(input row_t r, input string nm);
    pwm_in = 1'b1;
    tick(SYNC_STAGES + 1);
    check({nm, "_early"}, 32'({duty_valid, period_err}), 32'd0);
    tick(1);
    check(nm, outs(), 32'({r.v, r.e, r.s, r.d}));
    if (r.v) exp_valid = exp_valid + 1;
    if (r.e) exp_err   = exp_err + 1;
    tick(r.high - SYNC_STAGES - 2);
    pwm_in = 1'b0;
    tick(r.period - r.high);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    mon_valid = 0;
    mon_err   = 0;
    exp_valid = 0;
    exp_err   = 0;
    reset     = 1'b0;
    pwm_in    = 1'b0;

    // Each rise reports the period that preceded it.
    tbl[0]  = mk(250,  1000, 1'b0, 1'b0, 0,  1'b1);
    tbl[1]  = mk(250,  1000, 1'b1, 1'b0, 25, 1'b0);
    tbl[2]  = mk(995,  1000, 1'b1, 1'b0, 25, 1'b0);
    tbl[3]  = mk(5,    1000, 1'b1, 1'b0, 99, 1'b0);
    tbl[4]  = mk(250,  1000, 1'b1, 1'b0, 0,  1'b0);
    tbl[5]  = mk(250,  500,  1'b1, 1'b0, 25, 1'b0);
    tbl[6]  = mk(400,  1000, 1'b0, 1'b1, 25, 1'b0);
    tbl[7]  = mk(400,  1000, 1'b1, 1'b0, 40, 1'b0);
    tbl[8]  = mk(250,  1000, 1'b1, 1'b0, 40, 1'b0);
    tbl[9]  = mk(250,  1500, 1'b1, 1'b0, 25, 1'b0);
    tbl[10] = mk(250,  1000, 1'b0, 1'b1, 25, 1'b0);
    tbl[11] = mk(250,  1100, 1'b1, 1'b0, 25, 1'b0);
    tbl[12] = mk(1050, 1100, 1'b1, 1'b0, 25, 1'b0);
    tbl[13] = mk(300,  900,  1'b1, 1'b0, 99, 1'b0);
    tbl[14] = mk(300,  899,  1'b1, 1'b0, 30, 1'b0);
    tbl[15] = mk(300,  1000, 1'b0, 1'b1, 30, 1'b0);

    // Reset state and idle input.
    tick(3);
    check("reset_state", outs(), 32'({1'b0, 1'b0, 1'b1, 7'd0}));
    reset = 1'b1;
    tick(3000);
    check("idle_outputs", outs(), 32'({1'b0, 1'b0, 1'b1, 7'd0}));
    check("idle_no_pulses", 32'(mon_valid + mon_err), 32'd0);

    // Main table: duty values, saturation, period window edges, errors.
    for (int i = 0; i < N_ROWS; i++) begin
      apply_row(tbl[i], $sformatf("row%0d", i));
    end

    // Publish 30, then hold high: stale exactly 2000 cycles after the publish.
    pwm_in = 1'b1;
    tick(SYNC_STAGES + 2);
    check("hold_publish", outs(), 32'({1'b1, 1'b0, 1'b0, 7'd30}));
    exp_valid = exp_valid + 1;
    tick(TIMEOUT_CYCLES - 1);
    check("hold_before_timeout", 32'(stale), 32'd0);
    tick(1);
    check("hold_timeout", outs(), 32'({1'b0, 1'b0, 1'b1, 7'd30}));
    tick(100);
    pwm_in = 1'b0;
    tick(500);
    apply_row(mk(250, 1000, 1'b0, 1'b0, 30, 1'b1), "after_timeout_rise1");
    apply_row(mk(250, 1000, 1'b1, 1'b0, 25, 1'b0), "after_timeout_rise2");

    // Reset in the middle of a high phase.
    pwm_in = 1'b1;
    tick(SYNC_STAGES + 2);
    check("pre_reset_publish", outs(), 32'({1'b1, 1'b0, 1'b0, 7'd25}));
    exp_valid = exp_valid + 1;
    tick(100);
    #3 reset = 1'b0;
    #1;
    check("reset_async", outs(), 32'({1'b0, 1'b0, 1'b1, 7'd0}));
    pwm_in = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(20);
    apply_row(mk(250, 1000, 1'b0, 1'b0, 0, 1'b1), "post_reset_rise1");
    apply_row(mk(250, 1000, 1'b1, 1'b0, 25, 1'b0), "post_reset_rise2");

    tick(10);
    check("valid_pulse_total", 32'(mon_valid), 32'(exp_valid));
    check("err_pulse_total", 32'(mon_err), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the servo PWM serializers. Measures an incoming PWM waveform and recovers its duty cycle as a 0..99 step value, the same scale the serializers accept.
- Used for servo/PWM loop-back self-test and for decoding external RC-style PWM inputs into regfile-visible values.
- Single clock domain. Async input is synchronized internally.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on pwm_in (minimum 2).
- STEP_CYCLES, 20000, clock cycles per duty step (100 MHz / 20 ms period / 100 steps).
- MIN_PERIOD, 1800000, minimum accepted rising-to-rising period in cycles.
- MAX_PERIOD, 2200000, maximum accepted period in cycles.
- TIMEOUT_CYCLES, 4000000, cycles without a rising edge before the input is declared stale.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- pwm_in  in  1  asynchronous PWM input.
- duty  out  7  last accepted duty, 0..99.
- duty_valid  out  1  one-cycle pulse when duty is updated.
- period_err  out  1  one-cycle pulse when a measured period is out of range.
- stale  out  1  level; 1 when no valid period has been seen or a timeout has occurred.

Behaviour:
- Reset (reset=0, async): duty=0, duty_valid=0, period_err=0, stale=1. FSM goes to IDLE. All counters are cleared and synchronizer flops are set to 0. Reset asserted mid-measurement discards the partial measurement.
- Synchronizer: SYNC_STAGES flops, then one prev flop. rise = s & ~prev, fall = ~s & prev. Edges act 1 cycle after the last sync stage.
- Counters:
  - per_cnt counts cycles since the last rising edge and saturates at TIMEOUT_CYCLES.
  - step_cnt runs 0..STEP_CYCLES-1 while in HIGH; on wrap, hi_steps increments.
  - hi_steps saturates at 99.
  - Widths come from $clog2 of the respective maxima.
- FSM states:
  - IDLE: wait for rise. On rise: per_cnt=1, step_cnt=0, hi_steps=0, go HIGH. No publish.
  - HIGH: per_cnt++, step counting active. On fall: go LOW; hi_steps is frozen.
  - LOW: per_cnt++. On rise: evaluate the period P=per_cnt.
    - If MIN_PERIOD<=P<=MAX_PERIOD: duty<=hi_steps, duty_valid=1 on the next clock edge, stale<=0.
    - Otherwise: period_err=1, duty unchanged.
    - In both cases restart measurement (per_cnt=1, step_cnt=0, hi_steps=0) and go HIGH, so the same edge starts the next period.
- Duty arithmetic: duty = min(floor(high_cycles/STEP_CYCLES), 99). No divider is used; the value comes from step counting.
- Timeout: in HIGH or LOW, if per_cnt reaches TIMEOUT_CYCLES, set stale=1, go IDLE, and hold duty. This covers constant-high and constant-low input. No period_err is raised on timeout.
- Simultaneous events: a rise in the same cycle per_cnt hits TIMEOUT_CYCLES is handled as a timeout; the edge is ignored and IDLE waits for the next rise.
- duty_valid and period_err are mutually exclusive and never high for 2 consecutive cycles.
- Latency: duty and duty_valid are registered SYNC_STAGES+2 cycles after the pwm_in rising edge at the pin.

Test Plan (override STEP_CYCLES=10, MIN_PERIOD=900, MAX_PERIOD=1100, TIMEOUT_CYCLES=2000):
- Reset low then release, pwm_in=0 -> duty=0, stale=1, no pulses for 3000 cycles.
- Period 1000, high 250, 3 periods -> first rise produces no pulse; duty_valid pulses at rise 2 and rise 3 with duty=25; stale falls to 0 at the first pulse; the pulse lands SYNC_STAGES+2 cycles after the pin edge.
- Period 1000, high 995, then high 5 -> duty=99 (saturated), then duty=0.
- After duty=25 is valid, apply a 500-cycle period -> period_err pulses once, duty stays 25, stale stays 0. Resume 1000/400 -> duty=40.
- After a valid duty, hold pwm_in=1 -> stale=1 exactly 2000 cycles after the last rise, duty held. The next rise produces no pulse; the following valid period publishes.
- Assert reset in the middle of the HIGH phase (pwm_in is a 1000/250 stream) -> outputs go to reset values immediately. After release, the first publish is at the second rise with duty=25.
